nice_range_iterator: RTL

- Multi-channel hardware iterator: each channel is loaded with a range (first, last, step, mode) and emits its members one item at a time on a valid/ready stream.
- Parametrised successor of the iterator pattern: generalised in data width and channel count, adds down-counting, cyclic mode, abort and round-robin interleaving.
- Sits between configuration logic and any index consumer, such as address generators or table walkers.

---
 rtl/nice_range_iterator.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/nice_range_iterator.sv
`default_nettype none
// ============================================================================
// Module      : nice_range_iterator
// Description : Multi-channel range iterator. Each channel is loaded with
//               (first, last, step, mode) and emits the members of that range
//               one at a time on a shared valid/ready output stream. Running
//               channels share the output through round-robin arbitration.
//               Modes: ONCE_UP, ONCE_DOWN, CYCLIC_UP (runs until aborted).
// Ports       : clk, rst_n (async, active-low)
//               cfg_*    : configuration request/handshake, cfg_err reject pulse
//               abort_*  : per-channel abort request
//               out_*    : item stream (data, source channel, last flag)
//               ch_busy  : per-channel running flags
// Options     : NICE_RANGE_ITER_COUNT_EN adds cnt_sel/item_cnt and a
//               saturating 32-bit handshake counter per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module nice_range_iterator #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DATA_W-1:0] cfg_first,
    input  logic [DATA_W-1:0] cfg_last,
    input  logic [DATA_W-1:0] cfg_step,
    input  logic [1:0]        cfg_mode,
    output logic              cfg_err,
    input  logic              abort_valid,
    input  logic [CH_W-1:0]   abort_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,
    output logic [NUM_CH-1:0] ch_busy
`ifdef NICE_RANGE_ITER_COUNT_EN
    ,
    input  logic [CH_W-1:0]   cnt_sel,
    output logic [31:0]       item_cnt
`endif
);

    localparam logic [1:0] MODE_ONCE_UP   = 2'b00;
    localparam logic [1:0] MODE_ONCE_DOWN = 2'b01;
    localparam logic [1:0] MODE_CYCLIC_UP = 2'b10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [NUM_CH-1:0]              w_busy;
    logic [NUM_CH-1:0]              w_eligible;
    logic [NUM_CH-1:0]              w_cfg_load;
    logic [NUM_CH-1:0]              w_grant;
    logic [NUM_CH-1:0]              w_item_last;
    logic [NUM_CH-1:0][DATA_W-1:0]  w_cur_all;
    logic [(1<<CH_W)-1:0]           w_busy_pad;
    logic                           w_cfg_accept;
    logic                           w_cfg_bad;
    logic                           w_load_en;
    logic                           w_gnt_found;
    logic [CH_W-1:0]                w_gnt_ch;
    int                             w_idx;

    logic                           r_cfg_err;
    logic                           r_out_valid;
    logic                           r_out_last;
    logic [DATA_W-1:0]              r_out_data;
    logic [CH_W-1:0]                r_out_ch;
    logic [CH_W-1:0]                r_rr_ptr;

    // ------------------------------------------------------------------
    // Configuration acceptance
    // ------------------------------------------------------------------
    always_comb begin
        w_cfg_bad = 1'b0;
        case (cfg_mode)
            MODE_ONCE_UP,
            MODE_CYCLIC_UP: w_cfg_bad = (cfg_first > cfg_last);
            MODE_ONCE_DOWN: w_cfg_bad = (cfg_first < cfg_last);
            default:        w_cfg_bad = 1'b1;
        endcase
    end

    // Channel indices beyond NUM_CH read as busy so they are never accepted.
    always_comb begin
        w_busy_pad             = '1;
        w_busy_pad[NUM_CH-1:0] = w_busy;
    end

    assign cfg_ready    = ~w_busy_pad[cfg_ch];
    assign w_cfg_accept = cfg_valid & cfg_ready;
    assign w_load_en    = ~r_out_valid | out_ready;

    // ------------------------------------------------------------------
    // Per-channel iterator
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [0:0]        r_state;
        logic [0:0]        w_state_nxt;
        logic              w_run;
        logic [DATA_W-1:0] r_cur;
        logic [DATA_W-1:0] r_first;
        logic [DATA_W-1:0] r_last;
        logic [DATA_W-1:0] r_step;
        logic [1:0]        r_mode;
        logic [DATA_W:0]   w_up_sum;
        logic [DATA_W:0]   w_dn_bound;
        logic              w_is_down;
        logic              w_is_cyclic;
        logic              w_last_item;
        logic              w_abort_hit;
        logic [DATA_W-1:0] w_cur_nxt;

        assign w_abort_hit      = abort_valid & (abort_ch == CH_W'(gi)) & (r_state == ST_RUN);
        assign w_cfg_load[gi]   = w_cfg_accept & ~w_cfg_bad & (cfg_ch == CH_W'(gi));
        // An aborting channel is withheld from arbitration in the abort cycle.
        assign w_eligible[gi]   = (r_state == ST_RUN) & ~w_abort_hit;
        assign w_grant[gi]      = w_load_en & w_gnt_found & (w_gnt_ch == CH_W'(gi));

        // Bounds are evaluated one bit wider so nothing wraps past 0 or 2^DATA_W.
        assign w_is_down   = (r_mode == MODE_ONCE_DOWN);
        assign w_is_cyclic = (r_mode == MODE_CYCLIC_UP);
        assign w_up_sum    = {1'b0, r_cur} + {1'b0, r_step};
        assign w_dn_bound  = {1'b0, r_last} + {1'b0, r_step};
        assign w_last_item = w_is_down ? ({1'b0, r_cur} < w_dn_bound)
                                       : (w_up_sum > {1'b0, r_last});
        assign w_cur_nxt   = w_is_down ? (r_cur - r_step) : w_up_sum[DATA_W-1:0];

        assign w_item_last[gi] = w_last_item;
        assign w_cur_all[gi]   = r_cur;
        assign w_busy[gi]      = w_run;

        // State register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // Next-state logic
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_load[gi]) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_abort_hit) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_grant[gi] && w_last_item && !w_is_cyclic) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // Output decode
        always_comb begin
            w_run = (r_state == ST_RUN);
        end

        // Range registers; after a lap-final item the cursor returns to first.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cur   <= '0;
                r_first <= '0;
                r_last  <= '0;
                r_step  <= '0;
                r_mode  <= MODE_ONCE_UP;
            end else if (w_cfg_load[gi]) begin
                r_cur   <= cfg_first;
                r_first <= cfg_first;
                r_last  <= cfg_last;
                r_step  <= (cfg_step == '0) ? DATA_W'(1) : cfg_step;
                r_mode  <= cfg_mode;
            end else if (w_grant[gi]) begin
                r_cur   <= w_last_item ? r_first : w_cur_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration: search starts after the last granted channel
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_ch    = '0;
        w_idx       = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_CH;
            if (!w_gnt_found && w_eligible[w_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_ch    = CH_W'(w_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
            r_rr_ptr    <= '0;
        end else begin
            r_cfg_err <= w_cfg_accept & w_cfg_bad;
            if (w_load_en) begin
                r_out_valid <= w_gnt_found;
                if (w_gnt_found) begin
                    r_out_data <= w_cur_all[w_gnt_ch];
                    r_out_ch   <= w_gnt_ch;
                    r_out_last <= w_item_last[w_gnt_ch];
                    r_rr_ptr   <= w_gnt_ch;
                end
            end
        end
    end

    assign cfg_err   = r_cfg_err;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_last  = r_out_last;
    assign ch_busy   = w_busy;

`ifdef NICE_RANGE_ITER_COUNT_EN
    // ------------------------------------------------------------------
    // Per-channel handshake counters (saturating)
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0][31:0] w_cnt_all;
    logic                    w_out_hs;

    assign w_out_hs = r_out_valid & out_ready;

    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_cnt
        logic [31:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_cfg_accept && (cfg_ch == CH_W'(gc))) begin
                r_cnt <= '0;
            end else if (w_out_hs && (r_out_ch == CH_W'(gc)) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end

        assign w_cnt_all[gc] = r_cnt;
    end

    always_comb begin
        item_cnt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cnt_sel == CH_W'(k)) begin
                item_cnt = w_cnt_all[k];
            end
        end
    end
`endif

endmodule
`default_nettype wire
